filter_engine: RTL

Parametrised sample-processing engine between the ADC reader and the DAC writer; it replaces the fixed first-order IIR and external mute/bypass mux. Per accepted sample it produces one output in one of four runtime modes: mute, bypass, N-tap FIR or first-order IIR. Both filters share a single sequential multiply-accumulate datapath. Coefficients reset to parameter defaults and can be rewritten at runtime.

---
 rtl/filter_pkg.sv | 40 ++++
 rtl/filter_engine_mac.sv | 41 ++++
 rtl/filter_engine.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/filter_pkg.sv
// Shared types and helpers for the sample filter engine.
// Latency: n/a (types and combinational helper only).
// Backpressure: n/a.
package filter_pkg;

    typedef enum logic [1:0] {
        MODE_MUTE   = 2'd0,
        MODE_BYPASS = 2'd1,
        MODE_FIR    = 2'd2,
        MODE_IIR    = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_e;

    // Width of the generic saturation helper's input/output; any accumulator
    // narrower than this can be sign-extended into it without loss.
    localparam int SAT_W = 64;

    // Clamp a signed value to the range of a w-bit two's complement number.
    // The result is returned sign-extended; callers truncate to w bits.
    function automatic logic signed [SAT_W-1:0] sat(input logic signed [SAT_W-1:0] v,
                                                    input int                       w);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/filter_engine_mac.sv
// Shared signed multiply-accumulate: one COEF_W x DATA_W product per enabled cycle.
// Latency: sum_o is combinational (acc + product); the accumulator updates on the enabled edge.
// Backpressure: none; the controller sequences clr_i/en_i.
module mac_unit
    import filter_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int COEF_W = 18,
    parameter int ACC_W  = 38
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clr_i,
    input  logic                     en_i,
    input  logic signed [COEF_W-1:0] coef_i,
    input  logic signed [DATA_W-1:0] data_i,
    output logic signed [ACC_W-1:0]  sum_o
);

    localparam int PW = COEF_W + DATA_W;

    logic signed [PW-1:0]    prod;
    logic signed [ACC_W-1:0] acc_q;

    assign prod  = coef_i * data_i;
    // Value the accumulator takes on the next enabled edge; exposed so the
    // controller can register the final result without an extra cycle.
    assign sum_o = acc_q + {{(ACC_W - PW){prod[PW-1]}}, prod};

    // Accumulator: cleared when a new sample is accepted, summed while enabled.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q <= '0;
        end else if (clr_i) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= sum_o;
        end
    end

endmodule

// File: rtl/filter_engine.sv
// Per-sample engine: mute, bypass, N-tap FIR or first-order IIR over a shared MAC.
// Latency: TAPS+1 cycles (FIR), 3 (IIR), 1 (mute/bypass) from acceptance to sample_valid_o.
// Backpressure: none; strobes arriving while busy are dropped and flagged on sticky overrun_o.
module filter_engine
    import filter_pkg::*;
#(
    parameter int DATA_W        = 16,
    parameter int COEF_W        = 18,
    parameter int COEF_FRAC     = 16,
    parameter int TAPS          = 8,
    parameter int FIR_COEF_INIT = 8192,
    parameter int IIR_B1_INIT   = -62308,
    parameter int IIR_A1_INIT   = 58982
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        sample_valid_i,
    input  logic signed [DATA_W-1:0]    sample_i,
    input  logic [1:0]                  mode_i,
    input  logic                        coef_we_i,
    input  logic [$clog2(TAPS+2)-1:0]   coef_addr_i,
    input  logic signed [COEF_W-1:0]    coef_data_i,
    output logic signed [DATA_W-1:0]    sample_o,
    output logic                        sample_valid_o,
    output logic                        busy_o,
    output logic                        overrun_o
);

    // Sized so that TAPS full-scale products plus the IIR input term cannot wrap.
    localparam int ACC_W = DATA_W + COEF_W + $clog2(TAPS) + 1;
    localparam int KW    = $clog2(TAPS);

    state_e                   state_q;
    mode_e                    mode_q;
    logic [KW-1:0]            k_q;
    logic signed [DATA_W-1:0] x_q [TAPS];
    logic signed [COEF_W-1:0] fir_coef_q [TAPS];
    logic signed [COEF_W-1:0] b1_q;
    logic signed [COEF_W-1:0] a1_q;
    logic signed [DATA_W-1:0] y1_q;
    logic signed [DATA_W-1:0] sample_q;
    logic                     valid_q;
    logic                     overrun_q;

    logic                     accept;
    logic                     last_mac;
    logic signed [COEF_W-1:0] mac_coef;
    logic signed [DATA_W-1:0] mac_data;
    logic signed [ACC_W-1:0]  mac_sum;
    logic signed [ACC_W-1:0]  y_acc;
    logic signed [SAT_W-1:0]  y_ext;
    logic signed [DATA_W-1:0] y_sat;

    assign busy_o         = (state_q != IDLE);
    assign accept         = sample_valid_i && (state_q == IDLE);
    assign last_mac       = (mode_q == MODE_IIR) ? (k_q == KW'(1)) : (k_q == KW'(TAPS - 1));
    assign sample_o       = sample_q;
    assign sample_valid_o = valid_q;
    assign overrun_o      = overrun_q;

    // Operand select: FIR walks tap k over x[k]; IIR uses B1*x[1] then A1*y1.
    always_comb begin
        mac_coef = fir_coef_q[k_q];
        mac_data = x_q[k_q];
        if (mode_q == MODE_IIR) begin
            if (k_q == '0) begin
                mac_coef = b1_q;
                mac_data = x_q[1];
            end else begin
                mac_coef = a1_q;
                mac_data = y1_q;
            end
        end
    end

    mac_unit #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk_i  (clk_i),
        .rst_i  (reset_i),
        .clr_i  (accept),
        .en_i   (state_q == MAC),
        .coef_i (mac_coef),
        .data_i (mac_data),
        .sum_o  (mac_sum)
    );

    // Result from the final accumulator value: scale back from Q.COEF_FRAC
    // (arithmetic shift, floors), add the direct input term for IIR, saturate.
    always_comb begin
        y_acc = mac_sum >>> COEF_FRAC;
        if (mode_q == MODE_IIR) begin
            y_acc = y_acc + {{(ACC_W - DATA_W){x_q[0][DATA_W-1]}}, x_q[0]};
        end
        y_ext = {{(SAT_W - ACC_W){y_acc[ACC_W-1]}}, y_acc};
        y_sat = DATA_W'(sat(y_ext, DATA_W));
    end

    // Coefficient register file: writes only land while idle, so a running
    // computation never sees a coefficient change underneath it.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < TAPS; i++) begin
                fir_coef_q[i] <= COEF_W'(FIR_COEF_INIT);
            end
            b1_q <= COEF_W'(IIR_B1_INIT);
            a1_q <= COEF_W'(IIR_A1_INIT);
        end else if (coef_we_i && (state_q == IDLE)) begin
            if (int'(coef_addr_i) < TAPS) begin
                fir_coef_q[coef_addr_i[KW-1:0]] <= coef_data_i;
            end else if (int'(coef_addr_i) == TAPS) begin
                b1_q <= coef_data_i;
            end else if (int'(coef_addr_i) == TAPS + 1) begin
                a1_q <= coef_data_i;
            end
        end
    end

    // Control FSM with delay line, IIR history and registered outputs.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            mode_q    <= MODE_MUTE;
            k_q       <= '0;
            y1_q      <= '0;
            sample_q  <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                x_q[i] <= '0;
            end
        end else begin
            valid_q <= 1'b0;
            if (sample_valid_i && (state_q != IDLE)) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (sample_valid_i) begin
                        mode_q <= mode_e'(mode_i);
                        k_q    <= '0;
                        x_q[0] <= sample_i;
                        for (int i = 1; i < TAPS; i++) begin
                            x_q[i] <= x_q[i-1];
                        end
                        // Any non-IIR sample restarts the recursion from rest.
                        if (mode_e'(mode_i) != MODE_IIR) begin
                            y1_q <= '0;
                        end
                        case (mode_e'(mode_i))
                            MODE_MUTE: begin
                                sample_q <= '0;
                                valid_q  <= 1'b1;
                                state_q  <= OUT;
                            end
                            MODE_BYPASS: begin
                                sample_q <= sample_i;
                                valid_q  <= 1'b1;
                                state_q  <= OUT;
                            end
                            default: begin
                                state_q <= MAC;
                            end
                        endcase
                    end
                end
                MAC: begin
                    if (last_mac) begin
                        sample_q <= y_sat;
                        valid_q  <= 1'b1;
                        if (mode_q == MODE_IIR) begin
                            y1_q <= y_sat;
                        end
                        state_q <= OUT;
                    end else begin
                        k_q <= k_q + KW'(1);
                    end
                end
                OUT: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
